// File: rtl/hdb3_encode.sv
// HDB3 line encoder: unipolar NRZ in, dual-rail ternary out with AMI alternation
// and 000V / B00V substitution of every four-zero run, via a 4-deep tag delay line.
module hdb3_encode #(
  parameter logic INIT_POL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  input  logic i_data,
  output logic o_valid,
  output logic o_pos,
  output logic o_neg,
  output logic o_viol
);

  localparam logic [1:0] TAG_ZERO = 2'd0;
  localparam logic [1:0] TAG_ONE  = 2'd1;
  localparam logic [1:0] TAG_V    = 2'd2;
  localparam logic [1:0] TAG_B    = 2'd3;

  // slot 0 is the newest tag, slot 3 the oldest
  logic [1:0] slot_q [4];
  logic [1:0] slot_d [4];
  logic [2:0] fill_q,     fill_d;
  logic [1:0] zrun_q,     zrun_d;
  logic       parity_q,   parity_d;
  logic       last_pol_q, last_pol_d;
  logic       valid_q,    valid_d;
  logic       pos_q,      pos_d;
  logic       neg_q,      neg_d;
  logic       viol_q,     viol_d;
  logic       emit_s;
  logic [1:0] tag_out_s;

  function automatic logic is_mark(input logic [1:0] tag);
    return (tag == TAG_ONE) || (tag == TAG_B);
  endfunction

  // State register: delay line, counters, polarity tracking and output rails
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q     <= '{TAG_ZERO, TAG_ZERO, TAG_ZERO, TAG_ZERO};
      fill_q     <= 3'd0;
      zrun_q     <= 2'd0;
      parity_q   <= 1'b0;
      last_pol_q <= INIT_POL;
      valid_q    <= 1'b0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      fill_q     <= fill_d;
      zrun_q     <= zrun_d;
      parity_q   <= parity_d;
      last_pol_q <= last_pol_d;
      valid_q    <= valid_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      viol_q     <= viol_d;
    end
  end

  // Next state: shift/substitute on each beat, then map the outgoing tag to rails
  always_comb begin
    slot_d     = slot_q;
    fill_d     = fill_q;
    zrun_d     = zrun_q;
    parity_d   = parity_q;
    last_pol_d = last_pol_q;
    valid_d    = 1'b0;
    pos_d      = 1'b0;
    neg_d      = 1'b0;
    viol_d     = 1'b0;
    emit_s     = 1'b0;
    tag_out_s  = slot_q[3];

    if (i_valid) begin
      slot_d[3] = slot_q[2];
      slot_d[2] = slot_q[1];
      slot_d[1] = slot_q[0];
      if (i_data) begin
        slot_d[0] = TAG_ONE;
        zrun_d    = 2'd0;
        parity_d  = ~parity_q;
      end else if (zrun_q == 2'd3) begin
        // fourth zero: slots 3..1 already hold the first three zeros of the run
        slot_d[0] = TAG_V;
        zrun_d    = 2'd0;
        parity_d  = 1'b0;
        if (!parity_q) begin
          slot_d[3] = TAG_B;
        end else begin
          slot_d[3] = slot_q[2];
        end
      end else begin
        slot_d[0] = TAG_ZERO;
        zrun_d    = zrun_q + 2'd1;
      end
      if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end else begin
        fill_d = fill_q;
      end
      emit_s = (fill_q == 3'd4);
    end else begin
      emit_s = 1'b0;
    end

    if (emit_s) begin
      valid_d = 1'b1;
      case (tag_out_s)
        TAG_ONE, TAG_B: begin
          pos_d      = ~last_pol_q;
          neg_d      = last_pol_q;
          last_pol_d = ~last_pol_q;
        end
        TAG_V: begin
          pos_d  = last_pol_q;
          neg_d  = ~last_pol_q;
          viol_d = 1'b1;
        end
        TAG_ZERO: begin
          pos_d = 1'b0;
          neg_d = 1'b0;
        end
        default: begin
          pos_d = 1'b0;
          neg_d = 1'b0;
        end
      endcase
      if (!is_mark(tag_out_s)) begin
        last_pol_d = last_pol_q;
      end else begin
        last_pol_d = ~last_pol_q;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_pos   = pos_q;
  assign o_neg   = neg_q;
  assign o_viol  = viol_q;

endmodule

// File: tb/tb_hdb3_encode.sv
// Self-checking bench for hdb3_encode: directed cases plus a random stream checked
// against a whole-sequence HDB3 reference model and a polarity-rule decoder.
module tb_hdb3_encode;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_valid = 1'b0;
  logic i_data  = 1'b0;
  logic o_valid, o_pos, o_neg, o_viol;

  hdb3_encode #(.INIT_POL(1'b0)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_valid(o_valid),
    .o_pos  (o_pos),
    .o_neg  (o_neg),
    .o_viol (o_viol)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_bad = 0;
  int beats = 0;
  bit pend_v = 1'b0;
  int in_bits[$];
  int dut_sym[$];
  int dut_viol[$];
  int exp_sym[$];
  int exp_viol[$];
  int e_s[$];
  int e_v[$];
  int bits[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: account for the edge just past, sample outputs, drive the next input
  task automatic tick(input bit v, input bit d);
    int ev;
    @(negedge i_clk);
    if (pend_v) begin
      ev = (beats >= 4) ? 1 : 0;
      beats++;
    end else begin
      ev = 0;
    end
    chk("o_valid", int'(o_valid), ev);
    chk("rails_exclusive", int'(o_pos & o_neg), 0);
    if (o_valid) begin
      dut_sym.push_back(o_pos ? 1 : (o_neg ? -1 : 0));
      dut_viol.push_back(int'(o_viol));
    end
    i_valid = v;
    i_data  = d;
    pend_v  = v;
    if (v) in_bits.push_back(int'(d));
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = 1'b0;
    #1;
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_pos",   int'(o_pos),   0);
    chk("rst_o_neg",   int'(o_neg),   0);
    chk("rst_o_viol",  int'(o_viol),  0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    beats   = 0;
    pend_v  = 1'b0;
    in_bits.delete();
    dut_sym.delete();
    dut_viol.delete();
  endtask

  task automatic send_bits();
    foreach (bits[i]) tick(1'b1, bits[i][0]);
    repeat (3) tick(1'b0, 1'b0);
  endtask

  // HDB3 from the rules: AMI marks, then rewrite each 4-zero run after the fact
  task automatic model_encode();
    int last;
    int pulses;
    int run;
    last = -1;
    pulses = 0;
    run = 0;
    exp_sym.delete();
    exp_viol.delete();
    foreach (in_bits[i]) begin
      exp_viol.push_back(0);
      if (in_bits[i] != 0) begin
        last = -last;
        exp_sym.push_back(last);
        pulses++;
        run = 0;
      end else begin
        exp_sym.push_back(0);
        run++;
        if (run == 4) begin
          if (pulses % 2 == 0) begin
            last = -last;
            exp_sym[i-3] = last;
          end
          exp_sym[i]  = last;
          exp_viol[i] = 1;
          pulses = 0;
          run = 0;
        end
      end
    end
  endtask

  task automatic check_fixed(input string tag);
    int n;
    chk({tag, "_count"}, dut_sym.size(), e_s.size());
    n = (dut_sym.size() < e_s.size()) ? dut_sym.size() : e_s.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_sym%0d", tag, i), dut_sym[i], e_s[i]);
      chk($sformatf("%s_viol%0d", tag, i), dut_viol[i], e_v[i]);
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    int last;
    int lastv;
    int run;
    int maxrun;
    int s;
    int dec[$];
    model_encode();
    n = in_bits.size() - 4;
    chk({tag, "_count"}, dut_sym.size(), n);
    if (dut_sym.size() < n) n = dut_sym.size();
    last = -1;
    lastv = 0;
    run = 0;
    maxrun = 0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_sym"}, dut_sym[i], exp_sym[i]);
      chk({tag, "_viol"}, dut_viol[i], exp_viol[i]);
      s = dut_sym[i];
      dec.push_back((s != 0) ? 1 : 0);
      if (s == 0) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
        if (s == last) begin
          for (int k = 0; k < 4; k++) if (i - k >= 0) dec[i-k] = 0;
          if (lastv != 0) chk({tag, "_v_alternates"}, s, -lastv);
          lastv = s;
        end else begin
          last = s;
        end
      end
    end
    for (int i = 0; i < n; i++) chk({tag, "_decoded"}, dec[i], in_bits[i]);
    chk({tag, "_max_zero_run_le3"}, (maxrun <= 3) ? 1 : 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    chk("por_o_valid", int'(o_valid), 0);
    chk("por_o_pos",   int'(o_pos),   0);
    chk("por_o_neg",   int'(o_neg),   0);
    chk("por_o_viol",  int'(o_viol),  0);
    i_rst_n = 1'b1;

    bits = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    send_bits();
    e_s = '{1, 0, 0, 0, 1, -1};
    e_v = '{0, 0, 0, 0, 1, 0};
    check_fixed("s1");
    check_stream("s1");

    apply_reset();
    bits = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_bits();
    e_s = '{1, 0, 0, 1, -1, 0, 0, -1};
    e_v = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_fixed("s2");
    check_stream("s2");

    apply_reset();
    bits = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    send_bits();
    e_s = '{1, -1, 1, 0, 0, 1};
    e_v = '{0, 0, 0, 0, 0, 1};
    check_fixed("s3");
    check_stream("s3");

    // five idle clocks inside a zero run must not change the symbols
    apply_reset();
    bits = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, bits[i][0]);
      if (i == 6) repeat (5) tick(1'b0, 1'b0);
    end
    repeat (3) tick(1'b0, 1'b0);
    e_s = '{1, 0, 0, 1, -1, 0, 0, -1};
    e_v = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_fixed("s4");
    check_stream("s4");

    // odd parity and positive last mark in flight when reset hits
    apply_reset();
    bits = '{1, 0, 1, 1, 0, 0, 0};
    foreach (bits[i]) tick(1'b1, bits[i][0]);
    apply_reset();
    bits = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    send_bits();
    e_s = '{1, 0, 0, 0, 1};
    e_v = '{0, 0, 0, 0, 1};
    check_fixed("s5");
    check_stream("s5");

    apply_reset();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b0);
      tick(1'b1, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    repeat (3) tick(1'b0, 1'b0);
    check_stream("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
